multicycle_core: RTL and testbench

//  Parametrised multicycle RV32I-subset core: datapath, register file and FSM control in one block.

---
 rtl/multicycle_core.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
// Multicycle RV32I-subset core: FSM control, datapath and register file in one block.
// Instruction and data ports use a request/ready handshake so slow memories can stall the FSM.
module multicycle_core #(
    parameter int unsigned     XLEN     = 8,
    parameter int unsigned     NREGS    = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock_reg,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    output logic            imem_req,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic            dmem_we,
    output logic            dmem_req,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ready,
    input  logic [4:0]      dbg_sel,
    output logic [XLEN-1:0] dbg_data,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr,
    output logic [3:0]      state,
    output logic            zero,
    output logic            trap
);

    localparam int unsigned RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXEC_R = 4'd2;
    localparam logic [3:0] S_EXEC_I = 4'd3;
    localparam logic [3:0] S_ALUWB  = 4'd4;
    localparam logic [3:0] S_MEMADR = 4'd5;
    localparam logic [3:0] S_MEMRD  = 4'd6;
    localparam logic [3:0] S_MEMWB  = 4'd7;
    localparam logic [3:0] S_MEMWR  = 4'd8;
    localparam logic [3:0] S_BEQ    = 4'd9;
    localparam logic [3:0] S_JAL    = 4'd10;
    localparam logic [3:0] S_TRAP   = 4'd11;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LW  = 7'h03;
    localparam logic [6:0] OP_SW  = 7'h23;
    localparam logic [6:0] OP_BEQ = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6F;

    logic [3:0]      r_state;
    logic [3:0]      w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_old_pc;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_alu_out;
    logic [XLEN-1:0] r_data;
    logic            r_zero;
    logic            r_trap;
    logic [XLEN-1:0] r_regs [NREGS];

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_j;
    logic            w_is_r;
    logic            w_is_i;
    logic            w_is_lw;
    logic            w_is_sw;
    logic            w_is_beq;
    logic            w_is_jal;
    logic            w_legal;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_alu_b;
    logic [XLEN-1:0] w_alu_res;
    logic            w_rf_we;
    logic [XLEN-1:0] w_rf_wdata;

    // Instruction field extraction; immediates sign-extend then truncate to XLEN
    assign w_opcode = r_instr[6:0];
    assign w_rd     = r_instr[11:7];
    assign w_funct3 = r_instr[14:12];
    assign w_rs1    = r_instr[19:15];
    assign w_rs2    = r_instr[24:20];
    assign w_funct7 = r_instr[31:25];
    assign w_imm_i  = XLEN'($signed(r_instr[31:20]));
    assign w_imm_s  = XLEN'($signed({r_instr[31:25], r_instr[11:7]}));
    assign w_imm_b  = XLEN'($signed({r_instr[31], r_instr[7], r_instr[30:25],
                                     r_instr[11:8], 1'b0}));
    assign w_imm_j  = XLEN'($signed({r_instr[31], r_instr[19:12], r_instr[20],
                                     r_instr[30:21], 1'b0}));

    always_comb begin
        w_is_r   = 1'b0;
        w_is_i   = 1'b0;
        w_is_lw  = 1'b0;
        w_is_sw  = 1'b0;
        w_is_beq = 1'b0;
        w_is_jal = 1'b0;
        case (w_opcode)
            OP_R: w_is_r = ((w_funct7 == 7'h00) && (w_funct3 inside {3'd0, 3'd2, 3'd6, 3'd7}))
                         || ((w_funct7 == 7'h20) && (w_funct3 == 3'd0));
            OP_I:   w_is_i   = w_funct3 inside {3'd0, 3'd2, 3'd6, 3'd7};
            OP_LW:  w_is_lw  = (w_funct3 == 3'd2);
            OP_SW:  w_is_sw  = (w_funct3 == 3'd2);
            OP_BEQ: w_is_beq = (w_funct3 == 3'd0);
            OP_JAL: w_is_jal = 1'b1;
            default: ;
        endcase
    end

    assign w_legal = w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_beq | w_is_jal;

    // Register reads; indices beyond the implemented set read as zero
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        dbg_data  = '0;
        if (32'(w_rs1) < NREGS) begin
            w_rs1_val = r_regs[w_rs1[RIDX_W-1:0]];
        end
        if (32'(w_rs2) < NREGS) begin
            w_rs2_val = r_regs[w_rs2[RIDX_W-1:0]];
        end
        if (32'(dbg_sel) < NREGS) begin
            dbg_data = r_regs[dbg_sel[RIDX_W-1:0]];
        end
    end

    // ALU shared by the R and I execute states
    always_comb begin
        w_alu_b   = (r_state == S_EXEC_R) ? r_b : w_imm_i;
        w_alu_res = r_a + w_alu_b;
        case (w_funct3)
            3'd0: begin
                if ((r_state == S_EXEC_R) && w_funct7[5]) begin
                    w_alu_res = r_a - w_alu_b;
                end
            end
            3'd2:    w_alu_res = ($signed(r_a) < $signed(w_alu_b)) ? XLEN'(1) : '0;
            3'd6:    w_alu_res = r_a | w_alu_b;
            3'd7:    w_alu_res = r_a & w_alu_b;
            default: ;
        endcase
    end

    always_ff @(posedge clock_reg or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and port strobes; reset forces the strobes low immediately
    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = !reset;
                if (imem_ready) begin
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_is_r) begin
                    w_state_next = S_EXEC_R;
                end else if (w_is_i) begin
                    w_state_next = S_EXEC_I;
                end else if (w_is_lw || w_is_sw) begin
                    w_state_next = S_MEMADR;
                end else if (w_is_beq) begin
                    w_state_next = S_BEQ;
                end else if (w_is_jal) begin
                    w_state_next = S_JAL;
                end else begin
                    w_state_next = S_TRAP;
                end
            end
            S_EXEC_R, S_EXEC_I: w_state_next = S_ALUWB;
            S_ALUWB:            w_state_next = S_FETCH;
            S_MEMADR:           w_state_next = w_is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                dmem_req = !reset;
                if (dmem_ready) begin
                    w_state_next = S_MEMWB;
                end
            end
            S_MEMWB: w_state_next = S_FETCH;
            S_MEMWR: begin
                dmem_req = !reset;
                dmem_we  = !reset;
                if (dmem_ready) begin
                    w_state_next = S_FETCH;
                end
            end
            S_BEQ, S_JAL: w_state_next = S_FETCH;
            S_TRAP:       w_state_next = S_TRAP;
            default:      w_state_next = S_TRAP;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock_reg or posedge reset) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_old_pc  <= '0;
            r_instr   <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_out <= '0;
            r_data    <= '0;
            r_zero    <= 1'b0;
            r_trap    <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_instr  <= imem_rdata;
                        r_old_pc <= r_pc;
                        r_pc     <= r_pc + XLEN'(4);
                    end
                end
                S_DECODE: begin
                    r_a       <= w_rs1_val;
                    r_b       <= w_rs2_val;
                    r_alu_out <= r_old_pc + w_imm_b;
                    if (!w_legal) begin
                        r_trap <= 1'b1;
                    end
                end
                S_EXEC_R, S_EXEC_I: begin
                    r_alu_out <= w_alu_res;
                    r_zero    <= (w_alu_res == '0);
                end
                S_MEMADR: r_alu_out <= r_a + (w_is_sw ? w_imm_s : w_imm_i);
                S_MEMRD: begin
                    if (dmem_ready) begin
                        r_data <= dmem_rdata;
                    end
                end
                S_BEQ: begin
                    r_zero <= (r_a == r_b);
                    if (r_a == r_b) begin
                        r_pc <= r_alu_out;
                    end
                end
                S_JAL:   r_pc   <= r_old_pc + w_imm_j;
                S_TRAP:  r_trap <= 1'b1;
                default: ;
            endcase
        end
    end

    // Register file write port; x0 and unimplemented indices are discarded
    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_wdata = r_alu_out;
        case (r_state)
            S_ALUWB: w_rf_we = 1'b1;
            S_MEMWB: begin
                w_rf_we    = 1'b1;
                w_rf_wdata = r_data;
            end
            S_JAL: begin
                w_rf_we    = 1'b1;
                w_rf_wdata = r_pc;
            end
            default: ;
        endcase
        if ((w_rd == 5'd0) || (32'(w_rd) >= NREGS)) begin
            w_rf_we = 1'b0;
        end
    end

    always_ff @(posedge clock_reg or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_rf_we) begin
            r_regs[w_rd[RIDX_W-1:0]] <= w_rf_wdata;
        end
    end

    assign imem_addr  = r_pc;
    assign dmem_addr  = r_alu_out;
    assign dmem_wdata = r_b;
    assign pc         = r_pc;
    assign instr      = r_instr;
    assign state      = r_state;
    assign zero       = r_zero;
    assign trap       = r_trap;

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core (XLEN=8, NREGS=8): instruction table with scoreboard queue,
// plus directed sequences for data stalls, reset mid-access, trap and PC wrap.
module tb_multicycle_core;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMWR  = 4'd8;
    localparam logic [3:0] S_TRAP   = 4'd11;
    localparam int         NVEC     = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [7:0]  dmem_addr;
    logic [7:0]  dmem_wdata;
    logic        dmem_we;
    logic        dmem_req;
    logic [7:0]  dmem_rdata;
    logic        dmem_ready;
    logic [4:0]  dbg_sel = 5'd0;
    logic [7:0]  dbg_data;
    logic [7:0]  pc;
    logic [31:0] instr;
    logic [3:0]  state;
    logic        zero;
    logic        trap;

    multicycle_core #(.XLEN(8), .NREGS(8), .RESET_PC(8'h00)) dut (
        .clock_reg (clk),
        .reset     (reset),
        .imem_addr (imem_addr),
        .imem_req  (imem_req),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_we   (dmem_we),
        .dmem_req  (dmem_req),
        .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data),
        .pc        (pc),
        .instr     (instr),
        .state     (state),
        .zero      (zero),
        .trap      (trap)
    );

    always #5 clk = ~clk;

    // Memory models with a programmable number of wait cycles per access
    logic [31:0] imem [64];
    logic [7:0]  dmem [256];
    int imem_wait = 0;
    int dmem_wait = 0;
    int icnt = 0;
    int dcnt = 0;

    assign imem_rdata = imem[imem_addr[7:2]];
    assign imem_ready = imem_req && (icnt >= imem_wait);
    assign dmem_rdata = dmem[dmem_addr];
    assign dmem_ready = dmem_req && (dcnt >= dmem_wait);

    always @(posedge clk) begin
        icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
        if (dmem_req && dmem_we && dmem_ready) begin
            dmem[dmem_addr] <= dmem_wdata;
        end
    end

    typedef struct {
        string       name;
        logic [7:0]  addr;
        logic [31:0] word;
        int          iw;
        int          dw;
        logic [4:0]  rd;
        logic [7:0]  rd_val;
        logic [7:0]  pc_after;
        int          cycles;
        bit          zchk;
        bit          zval;
    } vec_t;

    vec_t tbl [NVEC];
    vec_t sb_q [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [7:0] a, input logic [31:0] w,
                                input int iw, input int dw, input logic [4:0] rd,
                                input logic [7:0] v, input logic [7:0] pa, input int c,
                                input bit zc, input bit zv);
        vec_t t;
        t.name = n; t.addr = a; t.word = w; t.iw = iw; t.dw = dw; t.rd = rd;
        t.rd_val = v; t.pc_after = pa; t.cycles = c; t.zchk = zc; t.zval = zv;
        return t;
    endfunction

    // Runs one instruction from FETCH back to FETCH; bounded so a stuck FSM cannot hang
    task automatic exec_one(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while ((state == S_FETCH) && (cyc < 40));
        while ((state != S_FETCH) && (cyc < 80)) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic read_reg(input logic [4:0] sel, output logic [7:0] v);
        dbg_sel = sel;
        #1;
        v = dbg_data;
    endtask

    initial begin
        int         cyc;
        int         reqs;
        vec_t       e;
        logic [7:0] v;

        tbl[0]  = mk("addi_x1",    8'h00, 32'h00500093, 0, 0, 5'd1, 8'h05, 8'h04, 4, 1'b1, 1'b0);
        tbl[1]  = mk("addi_x2_neg",8'h04, 32'hFFE00113, 0, 0, 5'd2, 8'hFE, 8'h08, 4, 1'b1, 1'b0);
        tbl[2]  = mk("add_wrap",   8'h08, 32'h002081B3, 1, 0, 5'd3, 8'h03, 8'h0C, 5, 1'b1, 1'b0);
        tbl[3]  = mk("sw_stall",   8'h0C, 32'h00302423, 0, 2, 5'd3, 8'h03, 8'h10, 6, 1'b0, 1'b0);
        tbl[4]  = mk("lw_stall",   8'h10, 32'h00802203, 0, 2, 5'd4, 8'h03, 8'h14, 7, 1'b0, 1'b0);
        tbl[5]  = mk("sub_zero",   8'h14, 32'h401082B3, 0, 0, 5'd5, 8'h00, 8'h18, 4, 1'b1, 1'b1);
        tbl[6]  = mk("slt_signed", 8'h18, 32'h00112333, 0, 0, 5'd6, 8'h01, 8'h1C, 4, 1'b1, 1'b0);
        tbl[7]  = mk("or",         8'h1C, 32'h0020E3B3, 0, 0, 5'd7, 8'hFF, 8'h20, 4, 1'b1, 1'b0);
        tbl[8]  = mk("andi",       8'h20, 32'h00F3F393, 0, 0, 5'd7, 8'h0F, 8'h24, 4, 1'b1, 1'b0);
        tbl[9]  = mk("slti_false", 8'h24, 32'hFFF3A313, 0, 0, 5'd6, 8'h00, 8'h28, 4, 1'b1, 1'b1);
        tbl[10] = mk("ori_iwait",  8'h28, 32'h08006293, 3, 0, 5'd5, 8'h80, 8'h2C, 7, 1'b1, 1'b0);
        tbl[11] = mk("beq_ne",     8'h2C, 32'h00208463, 0, 0, 5'd1, 8'h05, 8'h30, 3, 1'b1, 1'b0);
        tbl[12] = mk("beq_eq",     8'h30, 32'h00108463, 0, 0, 5'd1, 8'h05, 8'h38, 3, 1'b1, 1'b1);
        tbl[13] = mk("jal_link",   8'h38, 32'h008000EF, 0, 0, 5'd1, 8'h3C, 8'h40, 3, 1'b0, 1'b0);
        tbl[14] = mk("addi_x0",    8'h40, 32'h00500013, 0, 0, 5'd0, 8'h00, 8'h44, 4, 1'b0, 1'b0);

        for (int i = 0; i < 64; i++) imem[i] = 32'hFFFFFFFF;
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
        for (int i = 0; i < NVEC; i++) imem[tbl[i].addr[7:2]] = tbl[i].word;

        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", 32'(pc), 32'h00);
        check("rst_state", 32'(state), 32'(S_FETCH));
        check("rst_instr", instr, 32'h0);
        check("rst_trap", 32'(trap), 32'h0);
        check("rst_zero", 32'(zero), 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_dmem_req", 32'(dmem_req), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            check({tbl[i].name, "_start_pc"}, 32'(pc), 32'(tbl[i].addr));
            imem_wait = tbl[i].iw;
            dmem_wait = tbl[i].dw;
            sb_q.push_back(tbl[i]);
            exec_one(cyc);
            e = sb_q.pop_front();
            check({e.name, "_cycles"}, 32'(cyc), 32'(e.cycles));
            check({e.name, "_pc"}, 32'(pc), 32'(e.pc_after));
            check({e.name, "_state"}, 32'(state), 32'(S_FETCH));
            read_reg(e.rd, v);
            check({e.name, "_rd"}, 32'(v), 32'(e.rd_val));
            if (e.zchk) check({e.name, "_zero"}, 32'(zero), 32'(e.zval));
        end
        check("dmem8_stored", 32'(dmem[8]), 32'h03);
        read_reg(5'd9, v);
        check("dbg_out_of_range", 32'(v), 32'h00);

        // Store stalled by slow data memory, then abandoned by reset
        reset = 1'b1;
        imem_wait = 0;
        dmem_wait = 10;
        for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
        for (int i = 0; i < 64; i++) imem[i] = 32'hFFFFFFFF;
        imem[0] = 32'h00300193;
        imem[1] = 32'h00302423;
        @(posedge clk); #1;
        reset = 1'b0;
        exec_one(cyc);
        repeat (3) @(posedge clk);
        #1;
        check("memwr_state", 32'(state), 32'(S_MEMWR));
        check("memwr_req", 32'(dmem_req), 32'h1);
        check("memwr_we", 32'(dmem_we), 32'h1);
        check("memwr_addr", 32'(dmem_addr), 32'h08);
        check("memwr_wdata", 32'(dmem_wdata), 32'h03);
        @(posedge clk); #1;
        check("memwr_hold_req", 32'(dmem_req), 32'h1);
        check("memwr_hold_addr", 32'(dmem_addr), 32'h08);
        reset = 1'b1;
        #1;
        check("rst_mid_dmem_req", 32'(dmem_req), 32'h0);
        check("rst_mid_dmem_we", 32'(dmem_we), 32'h0);
        check("rst_mid_pc", 32'(pc), 32'h00);
        check("rst_mid_state", 32'(state), 32'(S_FETCH));
        @(posedge clk); #1;
        check("rst_mid_no_store", 32'(dmem[8]), 32'h00);

        // Illegal instruction enters TRAP and stops fetching
        dmem_wait = 0;
        imem[0] = 32'hFFFFFFFF;
        reset = 1'b0;
        @(posedge clk); #1;
        check("trap_decode_state", 32'(state), 32'(S_DECODE));
        check("trap_before", 32'(trap), 32'h0);
        @(posedge clk); #1;
        check("trap_state", 32'(state), 32'(S_TRAP));
        check("trap_flag", 32'(trap), 32'h1);
        reqs = 0;
        repeat (6) begin
            @(negedge clk);
            if (imem_req || dmem_req) reqs++;
        end
        check("trap_no_req", 32'(reqs), 32'h0);
        check("trap_sticky", 32'(trap), 32'h1);
        reset = 1'b1;
        #1;
        check("trap_cleared", 32'(trap), 32'h0);
        check("trap_rst_pc", 32'(pc), 32'h00);

        // PC wrap: jump back to 0xFC, then fetch there wraps PC+4 to 0x00
        imem[0]  = 32'hFFDFF06F;
        imem[63] = 32'h0000006F;
        @(posedge clk); #1;
        reset = 1'b0;
        exec_one(cyc);
        check("jal_neg_cycles", 32'(cyc), 32'h3);
        check("jal_neg_pc", 32'(pc), 32'hFC);
        @(posedge clk); #1;
        check("wrap_pc_plus4", 32'(pc), 32'h00);
        repeat (2) @(posedge clk);
        #1;
        check("wrap_jal_pc", 32'(pc), 32'hFC);
        check("wrap_jal_state", 32'(state), 32'(S_FETCH));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
